// File: rtl/keccak_rc_gen.sv
// Keccak-f[1600] iota round-constant generator: a bit-serial LFSR produces the
// seven live rc bits of each round, then the constant is held until accepted.
module keccak_rc_gen #(
  parameter int NROUNDS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        rc_ready_i,
  output logic [63:0] rc_o,
  output logic        rc_valid_o,
  output logic [4:0]  round_idx_o,
  output logic [7:0]  outR_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o
);

  // state | meaning
  // IDLE  | waiting for start (start is registered one cycle before launch)
  // GEN   | shifting one LFSR bit per cycle into rc (steps 0..6)
  // HOLD  | rc presented with rc_valid until rc_ready
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_e;

  localparam logic [4:0] LAST_IDX = 5'(NROUNDS - 1);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [2:0]  step_q, step_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] rc_q, rc_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        done_q, done_d;

  logic [7:0]  lfsr_next;
  logic [5:0]  bit_pos;
  logic        is_last;

  // x^8+x^6+x^5+x^4+1: feedback from R[7] into bits 0,4,5,6
  assign lfsr_next = {lfsr_q[6:0], 1'b0} ^ ({8{lfsr_q[7]}} & 8'h71);
  assign is_last   = (round_q == LAST_IDX);

  always_comb begin
    bit_pos = 6'd0;
    case (step_q)
      3'd0:    bit_pos = 6'd0;
      3'd1:    bit_pos = 6'd1;
      3'd2:    bit_pos = 6'd3;
      3'd3:    bit_pos = 6'd7;
      3'd4:    bit_pos = 6'd15;
      3'd5:    bit_pos = 6'd31;
      3'd6:    bit_pos = 6'd63;
      default: bit_pos = 6'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    step_d  = step_q;
    round_d = round_q;
    rc_d    = rc_q;
    lfsr_d  = lfsr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = GEN;
          step_d  = 3'd0;
          round_d = 5'd0;
          rc_d    = 64'd0;
          lfsr_d  = 8'h01;
        end else begin
          start_d = start_i;
        end
      end
      GEN: begin
        rc_d   = rc_q | (64'(lfsr_q[0]) << bit_pos);
        lfsr_d = lfsr_next;
        if (step_q == 3'd6) begin
          state_d = HOLD;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      HOLD: begin
        if (rc_ready_i) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GEN;
            round_d = round_q + 5'd1;
            rc_d    = 64'd0;
            step_d  = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_i) begin
      state_d = IDLE;
      start_d = 1'b0;
      done_d  = 1'b0;
      step_d  = 3'd0;
      rc_d    = 64'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      step_q  <= 3'd0;
      round_q <= 5'd0;
      rc_q    <= 64'd0;
      lfsr_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      step_q  <= step_d;
      round_q <= round_d;
      rc_q    <= rc_d;
      lfsr_q  <= lfsr_d;
      done_q  <= done_d;
    end
  end

  assign rc_o        = rc_q;
  assign rc_valid_o  = (state_q == HOLD);
  assign round_idx_o = round_q;
  assign outR_o      = lfsr_q;
  assign last_o      = (state_q == HOLD) && is_last;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: doc/keccak_rc_gen.md
KECCAK_RC_GEN -- requirements
Module: keccak_rc_gen

Interface
REQ-001 Parameter NROUNDS, default 24: number of round constants produced per permutation; legal range 1..24.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new permutation's constant sequence; honoured only in IDLE.
REQ-005 abort  input  1  synchronous abandon of the sequence; returns to IDLE.
REQ-006 rc_ready  input  1  downstream iota stage accepts the current rc.
REQ-007 rc  output  64  round constant for lane (0,0), XORed downstream into every z bit.
REQ-008 rc_valid  output  1  rc and round_idx valid.
REQ-009 round_idx  output  5  round number (0..NROUNDS-1) of the presented rc.
REQ-010 outR  output  8  LFSR state after generating the presented rc.
REQ-011 last  output  1  high with rc_valid when round_idx == NROUNDS-1.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last rc is accepted.

Function
REQ-014 LFSR: 8-bit register R, R[0] first bit; reset and permutation-start value 8'h01.
REQ-015 LFSR step: m = R[7]; R <= {R[6:0],0} with bits 0,4,5,6 each XORed with m (polynomial x^8+x^6+x^5+x^4+1).
REQ-016 FSM states: IDLE, GEN, HOLD.
REQ-017 IDLE: start=1 -> GEN; step counter 0; round counter 0; rc accumulator cleared to 0; LFSR 8'h01.
REQ-018 GEN: one LFSR bit per cycle; at step j (0..6), rc bit (2^j - 1) <= R[0], then R is stepped; all other rc bits stay 0.
REQ-019 GEN lasts exactly 7 cycles (j=0..6); after j=6 -> HOLD.
REQ-020 HOLD: rc_valid=1; rc, round_idx, outR, last stable until rc_ready=1.
REQ-021 HOLD with rc_ready=1, not last: round counter +1, rc cleared, step 0 -> GEN; LFSR continues from current value (no reload).
REQ-022 HOLD with rc_ready=1 and last: -> IDLE, done=1 for the next cycle only.
REQ-023 Latency: start sampled at edge N -> rc_valid high after edge N+8; each further round 7 cycles after acceptance.
REQ-024 rc_ready while rc_valid=0 is ignored; rc_valid never drops without acceptance, except on abort or reset.
REQ-025 start outside IDLE is ignored; start and done in the same cycle: start is accepted (back-to-back permutations).
REQ-026 abort in any state -> IDLE next cycle; rc_valid=0; no done pulse; abort overrides start and rc_ready in the same cycle.
REQ-027 round_idx never exceeds NROUNDS-1; no wrap.

Reset
REQ-028 rst_n=0 forces IDLE immediately, regardless of clk.
REQ-029 Reset values: rc=0, rc_valid=0, round_idx=0, outR=8'h01, last=0, busy=0, done=0.
REQ-030 Reset mid-sequence discards progress; the next start begins at round 0.

Verification
REQ-031 start, rc_ready tied 1 -> rc sequence 0x0000000000000001, 0x0000000000008082, 0x800000000000808A, ..., round 23 = 0x8000000080008008 with last=1; done pulses once.
REQ-032 rc_ready held 0 for 20 cycles in round 2 -> rc stays 0x800000000000808A, rc_valid stays 1; releasing ready -> round 3 = 0x8000000080008000.
REQ-033 start at edge N -> rc_valid rises after edge N+8; busy high from N+1.
REQ-034 abort during GEN of round 5 -> IDLE, rc_valid=0, no done; new start -> round 0 rc = 0x0000000000000001.
REQ-035 rst_n low asynchronously in HOLD -> outputs at reset values before next clk edge.
REQ-036 start asserted in the done cycle -> second sequence begins; its round 0 rc = 0x0000000000000001, outR reloaded.
